// File: rtl/tx_vp_pkg.sv
// Shared definitions for the sender-board vertical-pulse generator:
// controller state encoding and the default timing constants at 125 MHz.
package tx_vp_pkg;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_e;

  localparam int unsigned DEF_PER_F59 = 2085417;
  localparam int unsigned DEF_PER_F50 = 2500000;
  localparam int unsigned DEF_TOL     = 1024;

endpackage

// File: rtl/tx_vp_gen_sync.sv
// Brings the asynchronous source vsync into the clk domain and turns each
// rising edge into a registered one-cycle src_edge pulse.
module vs_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic vs_i,
  output logic src_edge_o
);

  logic sync1_q, sync2_q, prev_q, edge_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= vs_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      edge_q  <= sync2_q & ~prev_q;
    end
  end

  assign src_edge_o = edge_q;

endmodule

// File: rtl/tx_vp_gen.sv
// Vertical-pulse generator: follows a qualified source vsync when it is
// stable, otherwise free-runs at the nominal frame period.
module tx_vp_gen
  import tx_vp_pkg::*;
#(
  parameter int unsigned CNT_W   = 22,
  parameter int unsigned PER_F59 = DEF_PER_F59,
  parameter int unsigned PER_F50 = DEF_PER_F50,
  parameter int unsigned TOL     = DEF_TOL,
  parameter int unsigned LOCK_N  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       f50hz,
  input  logic       vs_in,
  output logic       tx_vp,
  output logic       frame_alt,
  output logic [7:0] frame_cnt,
  output logic       locked,
  output logic       over_vp,
  output logic       vs_err
);

  localparam logic [CNT_W:0] PER59_W = (CNT_W+1)'(PER_F59);
  localparam logic [CNT_W:0] PER50_W = (CNT_W+1)'(PER_F50);
  localparam logic [CNT_W:0] TOL_W   = (CNT_W+1)'(TOL);
  localparam logic [7:0]     LOCK_W  = 8'(LOCK_N);

  logic             src_edge;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] gen_cnt_q, gen_cnt_d;
  logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
  logic [7:0]       good_cnt_q, good_cnt_d;
  logic             per_ref_q, per_ref_d;
  logic             f50_q, f50_prev_q;
  logic             tx_vp_q, over_vp_q, vs_err_q, locked_q, frame_alt_q;
  logic [7:0]       frame_cnt_q;

  logic             fire, over_hit, err_hit;
  logic [CNT_W:0]   per_w, lo_w, hi_w, per_inc, gen_inc;
  logic             mode_chg, in_win, edge_ok, edge_bad, int_vp;

  vs_sync_edge u_sync (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .vs_i       (vs_in),
    .src_edge_o (src_edge)
  );

  always_comb begin
    per_w    = f50_q ? PER50_W : PER59_W;
    lo_w     = per_w - TOL_W;
    hi_w     = per_w + TOL_W;
    per_inc  = {1'b0, per_cnt_q} + 1'b1;
    gen_inc  = {1'b0, gen_cnt_q} + 1'b1;
    mode_chg = f50_q != f50_prev_q;
    in_win   = (per_inc >= lo_w) && (per_inc <= hi_w);
    edge_ok  = src_edge && per_ref_q && in_win;
    edge_bad = src_edge && per_ref_q && !in_win;
    // >= rather than == keeps gen_cnt bounded if a mode switch shortens PER
    int_vp   = gen_inc >= per_w;

    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    per_ref_d  = per_ref_q | src_edge;
    per_cnt_d  = src_edge ? '0 : ((&per_cnt_q) ? per_cnt_q : per_inc[CNT_W-1:0]);
    fire       = 1'b0;
    over_hit   = 1'b0;
    err_hit    = 1'b0;

    if (mode_chg) begin
      state_d    = ACQ;
      good_cnt_d = '0;
      per_ref_d  = 1'b0;
      fire       = int_vp;
    end else begin
      case (state_q)
        FREE: begin
          fire = int_vp;
          if (src_edge) state_d = ACQ;
        end
        ACQ: begin
          fire = int_vp;
          if (edge_ok) begin
            good_cnt_d = good_cnt_q + 8'd1;
            if (good_cnt_q + 8'd1 >= LOCK_W) begin
              state_d = LOCK;
              fire    = 1'b1;
            end
          end else if (edge_bad) begin
            err_hit    = 1'b1;
            good_cnt_d = '0;
          end else if (!src_edge && ({1'b0, per_cnt_q} > hi_w)) begin
            state_d    = FREE;
            good_cnt_d = '0;
            per_ref_d  = 1'b0;
          end
        end
        LOCK: begin
          if (edge_ok) begin
            fire = 1'b1;
          end else if (edge_bad) begin
            err_hit    = 1'b1;
            good_cnt_d = '0;
            state_d    = ACQ;
          end else if (!src_edge && (gen_inc >= hi_w)) begin
            fire       = 1'b1;
            over_hit   = 1'b1;
            state_d    = FREE;
            good_cnt_d = '0;
            per_ref_d  = 1'b0;
          end
        end
        default: state_d = FREE;
      endcase
    end

    gen_cnt_d = fire ? '0 : gen_inc[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FREE;
      gen_cnt_q   <= '0;
      per_cnt_q   <= '0;
      good_cnt_q  <= '0;
      per_ref_q   <= 1'b0;
      f50_q       <= 1'b0;
      f50_prev_q  <= 1'b0;
      tx_vp_q     <= 1'b0;
      over_vp_q   <= 1'b0;
      vs_err_q    <= 1'b0;
      locked_q    <= 1'b0;
      frame_alt_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      gen_cnt_q   <= gen_cnt_d;
      per_cnt_q   <= per_cnt_d;
      good_cnt_q  <= good_cnt_d;
      per_ref_q   <= per_ref_d;
      f50_q       <= f50hz;
      f50_prev_q  <= f50_q;
      tx_vp_q     <= fire;
      over_vp_q   <= over_hit;
      vs_err_q    <= err_hit;
      locked_q    <= (state_d == LOCK);
      frame_alt_q <= frame_alt_q ^ tx_vp_q;
      frame_cnt_q <= frame_cnt_q + {7'd0, tx_vp_q};
    end
  end

  assign tx_vp     = tx_vp_q;
  assign over_vp   = over_vp_q;
  assign vs_err    = vs_err_q;
  assign locked    = locked_q;
  assign frame_alt = frame_alt_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_tx_vp_gen.sv
// Randomized bench for tx_vp_gen, checked every cycle against a timestamp-based
// reference model; a second short-period instance exercises frame_cnt wrap.
module tb_tx_vp_gen;

  localparam int PER59 = 1000;
  localparam int PER50 = 1200;
  localparam int TOLB  = 16;
  localparam int LOCKN = 3;
  localparam int M_FREE = 0;
  localparam int M_ACQ  = 1;
  localparam int M_LOCK = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic f50hz = 1'b0;
  logic vs_in = 1'b0;
  logic tx_vp, frame_alt, locked, over_vp, vs_err;
  logic [7:0] frame_cnt;
  logic tx2, alt2, locked2, over2, err2;
  logic [7:0] cnt2;

  int testsRun = 0;
  int testsFailed = 0;

  tx_vp_gen #(.CNT_W(22), .PER_F59(PER59), .PER_F50(PER50), .TOL(TOLB), .LOCK_N(LOCKN)) dut (
    .clk(clk), .rst_n(rst_n), .f50hz(f50hz), .vs_in(vs_in),
    .tx_vp(tx_vp), .frame_alt(frame_alt), .frame_cnt(frame_cnt),
    .locked(locked), .over_vp(over_vp), .vs_err(vs_err)
  );

  tx_vp_gen #(.CNT_W(22), .PER_F59(40), .PER_F50(48), .TOL(4), .LOCK_N(LOCKN)) dutWrap (
    .clk(clk), .rst_n(rst_n), .f50hz(1'b0), .vs_in(1'b0),
    .tx_vp(tx2), .frame_alt(alt2), .frame_cnt(cnt2),
    .locked(locked2), .over_vp(over2), .vs_err(err2)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference model: tracks absolute cycle numbers of the last pulse and last
  // source edge, and replays the qualification rules on those intervals.
  int mN = 0;
  int mLastVp = 0;
  int mLastEdge = 0;
  int mGood = 0;
  int mSt = M_FREE;
  bit mPerRef = 0;
  int mFrames = 0;
  logic [7:0] vsSh = '0;
  logic [7:0] f50Sh = '0;
  bit prevRst = 1;
  int dutOver = 0;
  int dutErr = 0;

  always @(negedge clk) begin
    bit e, mc, inWin, intVp, eTx, eOver, eErr;
    int per, hi;
    mN++;
    if (!rst_n) begin
      vsSh = '0; f50Sh = '0;
      mSt = M_FREE; mGood = 0; mPerRef = 0; mFrames = 0; prevRst = 1;
      checkOutput("rstOuts", {tx_vp, over_vp, vs_err, locked, frame_alt, frame_cnt}, 32'd0);
    end else begin
      if (prevRst) begin
        prevRst = 0;
        mLastVp = mN;
        mLastEdge = mN;
        checkOutput("releaseOuts", {tx_vp, over_vp, vs_err, locked, frame_alt, frame_cnt}, 32'd0);
      end else begin
        e     = vsSh[3] && !vsSh[4];
        mc    = f50Sh[1] != f50Sh[2];
        per   = f50Sh[1] ? PER50 : PER59;
        hi    = per + TOLB;
        inWin = (mN - mLastEdge >= per - TOLB) && (mN - mLastEdge <= hi);
        intVp = (mN - mLastVp) >= per;
        eTx = 0; eOver = 0; eErr = 0;
        if (mc) begin
          mSt = M_ACQ; mGood = 0; mPerRef = 0; eTx = intVp;
        end else if (mSt == M_FREE) begin
          eTx = intVp;
          if (e) begin mSt = M_ACQ; mPerRef = 1; end
        end else if (mSt == M_ACQ) begin
          eTx = intVp;
          if (e && mPerRef && inWin) begin
            mGood++;
            if (mGood >= LOCKN) begin mSt = M_LOCK; eTx = 1; end
          end else if (e && mPerRef) begin
            eErr = 1; mGood = 0;
          end else if (e) begin
            mPerRef = 1;
          end else if (mN - mLastEdge - 1 > hi) begin
            mSt = M_FREE; mGood = 0; mPerRef = 0;
          end
        end else begin
          if (e && inWin) begin
            eTx = 1;
          end else if (e) begin
            eErr = 1; mGood = 0; mSt = M_ACQ;
          end else if (mN - mLastVp >= hi) begin
            eTx = 1; eOver = 1; mSt = M_FREE; mPerRef = 0; mGood = 0;
          end
        end
        checkOutput("outs", {tx_vp, over_vp, vs_err, locked, frame_alt, frame_cnt},
                    {19'd0, eTx, eOver, eErr, (mSt == M_LOCK), mFrames[0], mFrames[7:0]});
        if (eTx) begin mFrames++; mLastVp = mN; end
        if (e) mLastEdge = mN;
        if (over_vp) dutOver++;
        if (vs_err) dutErr++;
      end
      vsSh  = {vsSh[6:0], vs_in};
      f50Sh = {f50Sh[6:0], f50hz};
    end
  end

  logic [7:0] exp2 = '0;
  bit prevTx2 = 0;
  int pulses2 = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp2 = '0; prevTx2 = 0;
    end else begin
      if (prevTx2) checkOutput("wrapCnt", cnt2, exp2);
      if (tx2) begin exp2 = exp2 + 8'd1; pulses2++; end
      prevTx2 = tx2;
    end
  end

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  // Rises vs_in now and returns gap cycles later, so back-to-back calls
  // space source rising edges exactly gap cycles apart.
  task automatic applyStimulus(input int gap);
    for (int i = 0; i < gap; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) vs_in = 1'b1;
      if (i == 8) vs_in = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, required finish before 2000000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int per, r, k;
    rst_n = 1'b0; f50hz = 1'b0; vs_in = 1'b0;
    waitCycles(3);
    checkOutput("resetState", {tx_vp, over_vp, vs_err, locked, frame_alt, frame_cnt}, 32'd0);
    rst_n = 1'b1;

    waitCycles(3500);
    checkOutput("freeLocked", locked, 1'b0);
    checkOutput("freeFrames", frame_cnt, 8'd3);

    for (int i = 0; i < 5; i++) applyStimulus(1000 + $urandom_range(0, 10));
    applyStimulus(50);
    checkOutput("lockAcquired", locked, 1'b1);

    waitCycles(3000);
    checkOutput("timeoutUnlock", locked, 1'b0);
    checkOutput("timeoutOverCnt", dutOver, 1);

    for (int i = 0; i < 4; i++) applyStimulus(1005);
    applyStimulus(500);
    applyStimulus(50);
    checkOutput("badEdgeUnlock", locked, 1'b0);
    checkOutput("badEdgeErrCnt", dutErr, 1);
    waitCycles(2500);

    for (int i = 0; i < 4; i++) applyStimulus(992 + $urandom_range(0, 16));
    applyStimulus(100);
    checkOutput("lockBeforeMode", locked, 1'b1);
    f50hz = 1'b1;
    waitCycles(1100);
    checkOutput("modeUnlock", locked, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1192 + $urandom_range(0, 16));
    applyStimulus(50);
    checkOutput("relock50", locked, 1'b1);

    for (int i = 0; i < 14; i++) begin
      per = f50hz ? PER50 : PER59;
      r = $urandom_range(0, 9);
      if (r < 6) applyStimulus(per - 10 + $urandom_range(0, 20));
      else if (r == 6) applyStimulus($urandom_range(300, 900));
      else if (r == 7) applyStimulus(per + $urandom_range(40, 200));
      else if (r == 8) applyStimulus(2600);
      else begin
        f50hz = ~f50hz;
        applyStimulus((f50hz ? PER50 : PER59) - 8 + $urandom_range(0, 16));
      end
    end

    f50hz = 1'b0;
    waitCycles(20);
    for (int i = 0; i < 5; i++) applyStimulus(1000);
    applyStimulus(300);
    checkOutput("lockBeforeRst", locked, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRst", {tx_vp, over_vp, vs_err, locked, frame_alt, frame_cnt}, 32'd0);
    checkOutput("asyncRstWrap", {tx2, cnt2}, 32'd0);
    waitCycles(5);
    rst_n = 1'b1;
    k = 0;
    for (int i = 1; i <= 2000; i++) begin
      @(posedge clk);
      #1;
      if (tx_vp) begin k = i; break; end
    end
    checkOutput("firstVpAfterRst", k, 1000);
    waitCycles(1500);
    checkOutput("wrapReached", pulses2 >= 256, 1'b1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
